// File: rtl/one_port_mem_pkg.sv
// Shared sizing helpers for the single-port RAM: address width and row count
// for a given depth and column-mux exponent.
package one_port_mem_pkg;

   function automatic int addrWidthOf(input int words);
      return (words > 32'sd2) ? $clog2(words) : 32'sd1;
   endfunction

   // Rows needed when 2^muxFactor words share one physical row.
   function automatic int rowCountOf(input int words, input int muxFactor);
      return (words + (32'sd1 << muxFactor) - 32'sd1) >> muxFactor;
   endfunction

endpackage

// File: rtl/one_port_mem_if.sv
// Address/data/enable bundle of the single-port RAM; the memory is the slave.
interface one_port_mem_if #(
   parameter int addressWidth = 5,
   parameter int width        = 8
) ();
   logic [addressWidth-1:0] address;
   logic                    writeEnable;
   logic [width-1:0]        writeData;
   logic                    readEnable;
   logic [width-1:0]        readData;

   modport master (
      output address, writeEnable, writeData, readEnable,
      input  readData
   );

   modport slave (
      input  address, writeEnable, writeData, readEnable,
      output readData
   );
endinterface

// File: rtl/one_port_mem_row_array.sv
// Row-wide storage: combinational row read, clocked row write under a column mask.
module one_port_mem_row_array #(
   parameter int rowCount     = 32,
   parameter int rowWidth     = 8,
   parameter int rowAddrWidth = 5
) (
   input  logic                    clk,
   input  logic                    writeEnable,
   input  logic [rowAddrWidth-1:0] rowAddress,
   input  logic [rowWidth-1:0]     writeMask,
   input  logic [rowWidth-1:0]     writeRow,
   output logic [rowWidth-1:0]     readRow
);
   logic [rowWidth-1:0] mem [rowCount];

   // Read-modify-write of the addressed row: only masked column bits change.
   always_ff @(posedge clk) begin
      if (writeEnable) begin
         mem[rowAddress] <= (mem[rowAddress] & ~writeMask) | (writeRow & writeMask);
      end
   end

   always_comb begin
      if (32'(rowAddress) < 32'(rowCount)) begin
         readRow = mem[rowAddress];
      end else begin
         readRow = '0;
      end
   end
endmodule

// File: rtl/one_port_mem.sv
// Synchronous single-port RAM: address split into row/column, range check,
// write-over-read priority and a registered read port.
module one_port_mem
   import one_port_mem_pkg::*;
#(
   parameter int addresses = 32,
   parameter int width     = 8,
   parameter int muxFactor = 0
) (
   input logic          clk,
   input logic          resetN,
   one_port_mem_if.slave bus
);
   localparam int addressWidth = addrWidthOf(addresses);
   localparam int colCount     = 32'sd1 << muxFactor;
   localparam int colWidth     = (muxFactor > 32'sd0) ? muxFactor : 32'sd1;
   localparam int rowAddrWidth = (addressWidth > muxFactor) ? addressWidth - muxFactor : 32'sd1;
   localparam int rowWidth     = colCount * width;
   localparam int rowCount     = rowCountOf(addresses, muxFactor);
   localparam logic [rowWidth-1:0] wordOnes = rowWidth'({width{1'b1}});

   logic                    inRange;
   logic                    doWrite;
   logic                    doRead;
   logic [rowAddrWidth-1:0] rowAddr;
   logic [colWidth-1:0]     colSel;
   logic [rowWidth-1:0]     writeMask;
   logic [rowWidth-1:0]     writeRow;
   logic [rowWidth-1:0]     readRow;
   logic [width-1:0]        readWord;
   logic [width-1:0]        readDataR;

   // Address split and column steering; the mux factor is purely physical.
   always_comb begin
      inRange   = 32'(bus.address) < 32'(addresses);
      rowAddr   = rowAddrWidth'(bus.address >> muxFactor);
      colSel    = colWidth'(bus.address & addressWidth'(colCount - 32'sd1));
      doWrite   = resetN & bus.writeEnable & inRange;
      doRead    = bus.readEnable & ~bus.writeEnable;
      writeMask = wordOnes << (int'(colSel) * width);
      writeRow  = {colCount{bus.writeData}};
      readWord  = readRow[int'(colSel) * width +: width];
   end

   one_port_mem_row_array #(
      .rowCount    (rowCount),
      .rowWidth    (rowWidth),
      .rowAddrWidth(rowAddrWidth)
   ) rowArray (
      .clk        (clk),
      .writeEnable(doWrite),
      .rowAddress (rowAddr),
      .writeMask  (writeMask),
      .writeRow   (writeRow),
      .readRow    (readRow)
   );

   // Output register: write wins over read, out-of-range reads return zero.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         readDataR <= '0;
      end else if (doRead) begin
         readDataR <= inRange ? readWord : '0;
      end
   end

   assign bus.readData = readDataR;
endmodule

// File: tb/tb_one_port_mem.sv
// Drives five RAM configurations with shared stimulus and checks each against
// an array-based reference model of the read/write rules.
module tb_one_port_mem;
   import one_port_mem_pkg::*;

   localparam int aw = addrWidthOf(32);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetN;
   logic [aw-1:0] addr;
   logic          we;
   logic          re;
   logic [12:0]   wd;

   int checks = 0;
   int errors = 0;

   // Model 0: 32x8, model 1: 24x8, model 2: 32x13 (shared by all mux variants).
   int          depth [3] = '{32, 24, 32};
   logic [12:0] dmask [3] = '{13'h00FF, 13'h00FF, 13'h1FFF};
   logic [12:0] mem   [3][32];
   bit          vld   [3][32];
   logic [12:0] expRd [3];
   bit          known [3];

   one_port_mem_if #(.addressWidth(aw), .width(8))  busA ();
   one_port_mem_if #(.addressWidth(aw), .width(8))  busB ();
   one_port_mem_if #(.addressWidth(aw), .width(13)) busC ();
   one_port_mem_if #(.addressWidth(aw), .width(13)) busD ();
   one_port_mem_if #(.addressWidth(aw), .width(13)) busE ();

   assign busA.address = addr; assign busA.writeEnable = we; assign busA.readEnable = re; assign busA.writeData = wd[7:0];
   assign busB.address = addr; assign busB.writeEnable = we; assign busB.readEnable = re; assign busB.writeData = wd[7:0];
   assign busC.address = addr; assign busC.writeEnable = we; assign busC.readEnable = re; assign busC.writeData = wd;
   assign busD.address = addr; assign busD.writeEnable = we; assign busD.readEnable = re; assign busD.writeData = wd;
   assign busE.address = addr; assign busE.writeEnable = we; assign busE.readEnable = re; assign busE.writeData = wd;

   one_port_mem #(.addresses(32), .width(8),  .muxFactor(0)) dutA (.clk(clk), .resetN(resetN), .bus(busA.slave));
   one_port_mem #(.addresses(24), .width(8),  .muxFactor(0)) dutB (.clk(clk), .resetN(resetN), .bus(busB.slave));
   one_port_mem #(.addresses(32), .width(13), .muxFactor(0)) dutC (.clk(clk), .resetN(resetN), .bus(busC.slave));
   one_port_mem #(.addresses(32), .width(13), .muxFactor(1)) dutD (.clk(clk), .resetN(resetN), .bus(busD.slave));
   one_port_mem #(.addresses(32), .width(13), .muxFactor(2)) dutE (.clk(clk), .resetN(resetN), .bus(busE.slave));

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge: update the model from the sampled inputs, then compare.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
         if (!resetN) begin
            expRd[m] = 13'h0000;
            known[m] = 1'b1;
         end else if (we) begin
            if (int'(addr) < depth[m]) begin
               mem[m][addr] = wd & dmask[m];
               vld[m][addr] = 1'b1;
            end
         end else if (re) begin
            if (int'(addr) >= depth[m]) begin
               expRd[m] = 13'h0000;
               known[m] = 1'b1;
            end else begin
               expRd[m] = mem[m][addr];
               known[m] = vld[m][addr];
            end
         end
      end
      if (known[0]) checkVal("rd32x8",     32'(busA.readData), 32'(expRd[0]));
      if (known[1]) checkVal("rd24x8",     32'(busB.readData), 32'(expRd[1]));
      if (known[2]) begin
         checkVal("rd32x13mux0", 32'(busC.readData), 32'(expRd[2]));
         checkVal("rd32x13mux1", 32'(busD.readData), 32'(expRd[2]));
         checkVal("rd32x13mux2", 32'(busE.readData), 32'(expRd[2]));
      end
   endtask

   task automatic drive(input bit w, input bit r, input int a, input int d);
      we   = w;
      re   = r;
      addr = aw'(a);
      wd   = 13'(d);
      cycle();
   endtask

   initial begin
      for (int m = 0; m < 3; m++) begin
         known[m] = 1'b0;
         for (int i = 0; i < 32; i++) vld[m][i] = 1'b0;
      end
      resetN = 1'b0;
      drive(0, 0, 0, 0);
      drive(1, 1, 3, 'h1FFF);
      checkVal("resetRd", 32'(busA.readData), 32'h0);
      resetN = 1'b1;

      for (int i = 0; i < 32; i++) drive(1, 0, i, i);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         drive(0, 1, i, 0);
         checkVal("fillRd", 32'(busA.readData), 32'(i));
      end

      // Wide pattern, then a single column write that must not touch its row mates.
      for (int i = 0; i < 32; i++) drive(1, 0, i, i * 331 + 7);
      for (int i = 0; i < 32; i++) drive(0, 1, i, 0);
      drive(1, 0, 6, 'h1ABC);
      for (int i = 4; i < 8; i++) drive(0, 1, i, 0);

      drive(1, 0, 5, 5);
      drive(0, 1, 5, 0);
      checkVal("holdFirst", 32'(busA.readData), 32'h5);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 9, 'h1FFF);
         checkVal("hold", 32'(busA.readData), 32'h5);
      end

      drive(1, 0, 3, 'h11);
      drive(1, 0, 4, 'h22);
      drive(0, 1, 4, 0);
      drive(1, 1, 3, 'hAA);
      checkVal("simulHold", 32'(busA.readData), 32'h22);
      drive(0, 1, 3, 0);
      checkVal("simulWritten", 32'(busA.readData), 32'hAA);

      drive(1, 0, 31, 'h1F);
      drive(0, 1, 31, 0);
      checkVal("preReset", 32'(busA.readData), 32'h1F);
      resetN = 1'b0;
      drive(1, 1, 31, 'hFF);
      checkVal("midReset", 32'(busA.readData), 32'h0);
      resetN = 1'b1;
      drive(0, 1, 31, 0);
      checkVal("postReset", 32'(busA.readData), 32'h1F);

      drive(0, 1, 5, 0);
      checkVal("depth24Pre", 32'(busB.readData), 32'h5);
      drive(1, 0, 27, 'h55);
      drive(0, 1, 27, 0);
      checkVal("depth24Oor", 32'(busB.readData), 32'h0);
      checkVal("depth32At27", 32'(busA.readData), 32'h55);

      for (int n = 0; n < 3000; n++) begin
         resetN = ($urandom_range(0, 63) != 0);
         drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 8191)));
      end
      resetN = 1'b1;
      for (int i = 0; i < 32; i++) drive(0, 1, i, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/one_port_mem.md
# one_port_mem

Synchronous single-port RAM (`onePortMem`): one shared address bus, one write port and one registered read port on a single clock. It is the generic behavioural memory used wherever a block needs local storage. The `muxFactor` parameter sets the physical column-mux organisation only and never changes the functional behaviour.

## Interface
- `addresses`, 32: number of words; any value ≥ 2, need not be a power of two.
- `width`, 8: word width in bits, ≥ 1.
- `muxFactor`, 0: column-mux exponent. 0 means one word per row; N means 2^N words share a row. Must satisfy 2^N ≤ `addresses`.
- `addressWidth` (localparam): `$clog2(addresses)`, minimum 1.

Ports:
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `resetN`  in  1: reset, synchronous and active-low.
- `address`  in  `addressWidth`: word address, shared by read and write.
- `writeEnable`  in  1: when high, write `writeData` to `address` at the next rising edge.
- `writeData`  in  `width`: data to write.
- `readEnable`  in  1: when high, read `address` at the next rising edge.
- `readData`  out  `width`: registered read data.

## Operation
- Write: on a rising edge with `resetN`=1, `writeEnable`=1 and `address` < `addresses`, the word at `address` becomes `writeData`.
- Read: on a rising edge with `resetN`=1, `readEnable`=1, `writeEnable`=0 and `address` < `addresses`, `readData` is loaded with the stored word.
- Read hold: when `readEnable`=0, `readData` holds its previous value.
- Simultaneous read and write (both enables high): the write is performed and the read is ignored. `readData` holds. This is a single-port array, so write has priority.
- Out-of-range address (`address` ≥ `addresses`, possible only when `addresses` is not a power of two):
  - writes are dropped;
  - reads load 0.
- Reset: `resetN`=0 at a rising edge clears `readData` to 0 and suppresses any read or write in that cycle. Array contents are not reset and are undefined until written.
- Column-mux organisation:
  - row = `address >> muxFactor`; column = `address[muxFactor-1:0]`.
  - The array holds ceil(`addresses` / 2^`muxFactor`) rows of 2^`muxFactor`·`width` bits.
  - A write is a read-modify-write of only the selected column slice within the same edge; other columns are unchanged.
  - A read selects the column slice from the row.

## Timing
- Write latency 1: data written at edge k is readable by a read issued at edge k+1 or later.
- Read latency 1: `readData` is valid after the edge that samples `readEnable`=1 and stays stable until the next enabled read or reset.
- No combinational path from any input to `readData`.
- Back-to-back reads at consecutive addresses return one word per cycle.
- Reset asserted mid-sequence: `readData` is 0 after that edge. Words written before reset remain readable after reset is released.

## Structure
- Shared package: a `clog2`-based address-width helper and a function for the row count, ceil(`addresses` / 2^`muxFactor`).
- One sub-module, `one_port_mem_row_array`: a row-wide storage array with row read and row write-with-column-mask.
- The top level does address split, range check, enable priority and the output register.

## Test plan
- Fill then read back: `addresses`=32, `width`=8. Write word i with value i for i = 0..31, idle 10 cycles, then read i = 0..31 with `readEnable`=1. One cycle after each read edge, `readData` = i.
- Read hold: read address 5 (value 5), then deassert `readEnable` and change `address` to 9. `readData` stays 5 for every following cycle.
- Simultaneous enables: memory holds 0x11 at address 3. With `readData`=0x22, drive `writeEnable`=1, `readEnable`=1, `address`=3, `writeData`=0xAA. `readData` stays 0x22; the next read of address 3 returns 0xAA.
- Reset mid-read: `readData`=0x1F, then `resetN`=0 for one edge. `readData` becomes 0; after release, reading address 31 returns 0x1F.
- Non-power-of-two depth: `addresses`=24. A write of 0x55 to address 27 is dropped and a read of 27 returns 0; addresses 0..23 read back correctly.
- Mux variants: repeat the fill/readback with `muxFactor` = 0, 1, 2 and `width`=13. Results are identical, and a column write never disturbs neighbouring words in the same row.
